// File: rtl/puf_axil_ctrl.sv
// AXI4-Lite controller for the arbiter PUF core.
// Runs NEVAL launches and reports the majority-voted response bit.
module puf_axil_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int CHAL_WIDTH         = 64,
  parameter int TIMEOUT_CYCLES     = 1024,
  parameter int SETTLE_CYCLES      = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [CHAL_WIDTH-1:0]           puf_challenge,
  output logic                            puf_fire,
  input  logic                            puf_valid,
  input  logic                            puf_response,
  output logic                            irq
);

  localparam int NW = CHAL_WIDTH / 32;
  localparam int CMAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ?
                        TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ST_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_SETTLE,
    S_FINISH
  } state_t;

  state_t state, state_nxt;

  logic        aw_rdy;
  logic        bvalid;
  logic        ar_rdy;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] rdata_nxt;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  wr_idx;
  logic [3:0]  rd_idx;

  logic          irq_en;
  logic [7:0]    neval;
  logic          busy;
  logic          done;
  logic          tmo;
  logic          maj;
  logic [7:0]    ones;
  logic [7:0]    evals;
  logic [31:0]   chal_w [NW];
  logic [CW-1:0] cnt;

  logic       start_acc;
  logic       launch;
  logic       hit;
  logic       last;
  logic       expire;
  logic       settle_done;
  logic [7:0] neval_eff;
  logic [7:0] ones_inc;
  logic [7:0] evals_inc;
  logic       maj_nxt;

  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                    S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_idx = S_AXI_AWADDR[5:2];
  assign rd_idx = S_AXI_ARADDR[5:2];
  assign wr_en  = aw_rdy & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en  = ar_rdy & S_AXI_ARVALID;

  assign S_AXI_AWREADY = aw_rdy;
  assign S_AXI_WREADY  = aw_rdy;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = ar_rdy;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = 2'b00;

  assign irq = irq_en & (done | tmo);

  for (genvar k = 0; k < NW; k++) begin : g_chal
    assign puf_challenge[k*32 +: 32] = chal_w[k];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_rdy <= 1'b0;
      bvalid <= 1'b0;
      ar_rdy <= 1'b0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      aw_rdy <= S_AXI_AWVALID & S_AXI_WVALID
                & !bvalid & !aw_rdy;
      if (wr_en) begin
        bvalid <= 1'b1;
      end else if (S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
      ar_rdy <= S_AXI_ARVALID & !rvalid & !ar_rdy;
      if (rd_en) begin
        rvalid <= 1'b1;
        rdata  <= rdata_nxt;
      end else if (S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata_nxt = '0;
    case (rd_idx)
      4'd0: rdata_nxt = {16'd0, neval, 6'd0, irq_en, 1'b0};
      4'd1: rdata_nxt = {29'd0, tmo, done, busy};
      4'd2: rdata_nxt = {8'd0, evals, ones, 7'd0, maj};
      default: rdata_nxt = '0;
    endcase
    for (int k = 0; k < NW; k++) begin
      if (rd_idx == 4'(k + 4)) rdata_nxt = chal_w[k];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start_acc) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT: begin
        if (hit)         state_nxt = last ? S_FINISH : S_SETTLE;
        else if (expire) state_nxt = S_IDLE;
      end
      S_SETTLE: if (settle_done) state_nxt = S_LAUNCH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    neval_eff   = (neval == 8'd0) ? 8'd1 : neval;
    ones_inc    = ones + {7'd0, puf_response};
    evals_inc   = evals + 8'd1;
    maj_nxt     = {ones_inc, 1'b0} > {1'b0, neval_eff};
    start_acc   = wr_en && wr_idx == 4'd0
                  && S_AXI_WSTRB[0] && S_AXI_WDATA[0]
                  && !busy && state == S_IDLE;
    launch      = state == S_LAUNCH;
    hit         = state == S_WAIT && puf_valid;
    last        = hit && evals_inc == neval_eff;
    expire      = state == S_WAIT && !puf_valid
                  && cnt == TO_LAST;
    settle_done = state == S_SETTLE && cnt == ST_LAST;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt      <= '0;
      puf_fire <= 1'b0;
    end else begin
      puf_fire <= launch;
      if (launch || hit) begin
        cnt <= '0;
      end else if (state == S_WAIT || state == S_SETTLE) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Flag sets are placed after the W1C clears so a same-cycle set wins.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      irq_en <= 1'b0;
      neval  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      tmo    <= 1'b0;
      maj    <= 1'b0;
      ones   <= '0;
      evals  <= '0;
      for (int k = 0; k < NW; k++) chal_w[k] <= '0;
    end else begin
      if (wr_en && wr_idx == 4'd0) begin
        if (S_AXI_WSTRB[0]) irq_en <= S_AXI_WDATA[1];
        if (S_AXI_WSTRB[1] && !busy) neval <= S_AXI_WDATA[15:8];
      end
      if (wr_en && wr_idx == 4'd1 && S_AXI_WSTRB[0]) begin
        if (S_AXI_WDATA[1]) done <= 1'b0;
        if (S_AXI_WDATA[2]) tmo  <= 1'b0;
      end
      for (int k = 0; k < NW; k++) begin
        if (wr_en && !busy && wr_idx == 4'(k + 4)) begin
          for (int b = 0; b < 4; b++) begin
            if (S_AXI_WSTRB[b])
              chal_w[k][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
          end
        end
      end
      if (start_acc) begin
        busy  <= 1'b1;
        done  <= 1'b0;
        tmo   <= 1'b0;
        maj   <= 1'b0;
        ones  <= '0;
        evals <= '0;
      end
      if (hit) begin
        ones  <= ones_inc;
        evals <= evals_inc;
        if (last) begin
          maj  <= maj_nxt;
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
      if (expire) begin
        tmo  <= 1'b1;
        busy <= 1'b0;
        maj  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_puf_axil_ctrl.sv
// Directed self-checking bench for puf_axil_ctrl.
// Short timeout parameter keeps the timeout scenario brief.
module tb_puf_axil_ctrl;

  localparam int TO = 64;
  localparam int SC = 4;

  logic        clk;
  logic        rst_n;
  logic [5:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [5:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [63:0] chal;
  logic        fire;
  logic        pvalid;
  logic        presp;
  logic        irq;

  int checks;
  int passed;
  int cyc;
  int fire_cnt;

  puf_axil_ctrl #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6),
    .CHAL_WIDTH(64),
    .TIMEOUT_CYCLES(TO),
    .SETTLE_CYCLES(SC)
  ) dut (
    .ACLK(clk),
    .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr),
    .S_AXI_AWPROT(awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .puf_challenge(chal),
    .puf_fire(fire),
    .puf_valid(pvalid),
    .puf_response(presp),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    fire_cnt = 0;
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (fire) fire_cnt = fire_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  task automatic axi_write(input logic [5:0] a,
                           input logic [31:0] d,
                           input logic [3:0] s);
    int n;
    awaddr = a;
    wdata = d;
    wstrb = s;
    awvalid = 1'b1;
    wvalid = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!awready && n < 50);
    if (!awready) begin
      checks++;
      $display("FAIL wr_hs a=%h: got awready=0 want 1", a);
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a,
                          output logic [31:0] d);
    int n;
    araddr = a;
    arvalid = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!arready && n < 50);
    if (!arready) begin
      checks++;
      $display("FAIL rd_hs a=%h: got arready=0 want 1", a);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    d = rdata;
    if (!rvalid) begin
      checks++;
      $display("FAIL rd_valid a=%h: got 0 want 1", a);
    end
  endtask

  task automatic wait_done(output logic [31:0] st);
    int n;
    n = 0;
    do begin
      axi_read(6'h04, st);
      n++;
    end while ((st & 32'h6) == 0 && n < 100);
    if ((st & 32'h6) == 0) begin
      checks++;
      $display("FAIL wait_done: got %h want flag", st);
    end
  endtask

  task automatic run_evals(input int n, input logic [31:0] pat,
                           output int gap);
    int t_prev;
    int w;
    gap = 1000;
    t_prev = -1;
    for (int i = 0; i < n; i++) begin
      w = 0;
      do begin
        @(posedge clk); #1;
        w++;
      end while (!fire && w < 200);
      if (!fire) begin
        checks++;
        $display("FAIL fire_wait %0d: got 0 want 1", i);
      end
      if (t_prev >= 0 && cyc - t_prev < gap) gap = cyc - t_prev;
      t_prev = cyc;
      repeat (2) @(posedge clk);
      #1;
      pvalid = 1'b1;
      presp = pat[i];
      @(posedge clk); #1;
      pvalid = 1'b0;
      presp = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({fire, irq, awready, wready, bvalid, arready, rvalid}
        !== 7'd0 || chal !== 64'd0 || rdata !== 32'd0) begin
      $display("FAIL rst_out: got f%b i%b c%h r%h want 0",
               fire, irq, chal, rdata);
    end else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      axi_read(6'(i * 4), d);
      checks++;
      if (d !== 32'd0) begin
        $display("FAIL rst_reg %0d: got %h want 0", i, d);
      end else passed++;
    end
    checks++;
    if ({bresp, rresp} !== 4'd0) begin
      $display("FAIL resp: got %b want 0", {bresp, rresp});
    end else passed++;
  endtask

  task automatic test_chal();
    logic [31:0] d;
    axi_write(6'h10, 32'hDEADBEEF, 4'hF);
    axi_write(6'h14, 32'h12345678, 4'hF);
    checks++;
    if (chal !== 64'h12345678DEADBEEF) begin
      $display("FAIL chal_out: got %h want 12345678deadbeef", chal);
    end else passed++;
    axi_read(6'h10, d);
    checks++;
    if (d !== 32'hDEADBEEF) begin
      $display("FAIL chal0_rd: got %h want deadbeef", d);
    end else passed++;
    axi_read(6'h14, d);
    checks++;
    if (d !== 32'h12345678) begin
      $display("FAIL chal1_rd: got %h want 12345678", d);
    end else passed++;
  endtask

  task automatic test_majority5();
    logic [31:0] d;
    int base;
    int gap;
    base = fire_cnt;
    axi_write(6'h00, 32'h0000_0501, 4'hF);
    run_evals(5, 32'h0000_000B, gap);
    wait_done(d);
    checks++;
    if (d !== 32'h2) begin
      $display("FAIL maj5_status: got %h want 2", d);
    end else passed++;
    axi_read(6'h08, d);
    checks++;
    if (d !== 32'h0005_0301) begin
      $display("FAIL maj5_result: got %h want 00050301", d);
    end else passed++;
    checks++;
    if (fire_cnt - base !== 5) begin
      $display("FAIL maj5_fires: got %0d want 5", fire_cnt - base);
    end else passed++;
    checks++;
    if (gap < SC + 2) begin
      $display("FAIL maj5_gap: got %0d want >=%0d", gap, SC + 2);
    end else passed++;
  endtask

  task automatic test_majority4();
    logic [31:0] d;
    int gap;
    axi_write(6'h00, 32'h0000_0401, 4'hF);
    run_evals(4, 32'h0000_0003, gap);
    wait_done(d);
    axi_read(6'h08, d);
    checks++;
    if (d !== 32'h0004_0200) begin
      $display("FAIL maj4_result: got %h want 00040200", d);
    end else passed++;
    checks++;
    if (irq !== 1'b0) begin
      $display("FAIL maj4_irq_off: got %b want 0", irq);
    end else passed++;
    axi_write(6'h00, 32'h0000_0402, 4'hF);
    checks++;
    if (irq !== 1'b1) begin
      $display("FAIL maj4_irq_on: got %b want 1", irq);
    end else passed++;
    axi_read(6'h00, d);
    checks++;
    if (d !== 32'h0000_0402) begin
      $display("FAIL ctrl_rd: got %h want 00000402", d);
    end else passed++;
    axi_write(6'h04, 32'h2, 4'hF);
    checks++;
    if (irq !== 1'b0) begin
      $display("FAIL maj4_w1c: got %b want 0", irq);
    end else passed++;
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    int k;
    axi_write(6'h00, 32'h0000_0103, 4'hF);
    checks++;
    if (fire !== 1'b0) begin
      $display("FAIL lat_t1: got fire=%b want 0", fire);
    end else passed++;
    @(posedge clk); #1;
    checks++;
    if (fire !== 1'b1 || irq !== 1'b0) begin
      $display("FAIL lat_t2: got f%b i%b want f1 i0", fire, irq);
    end else passed++;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!irq && k < TO + 20);
    checks++;
    if (k !== TO) begin
      $display("FAIL tmo_cycles: got %0d want %0d", k, TO);
    end else passed++;
    axi_read(6'h04, d);
    checks++;
    if (d !== 32'h4) begin
      $display("FAIL tmo_status: got %h want 4", d);
    end else passed++;
    axi_read(6'h08, d);
    checks++;
    if (d !== 32'h0) begin
      $display("FAIL tmo_result: got %h want 0", d);
    end else passed++;
    axi_write(6'h04, 32'h4, 4'h1);
    checks++;
    if (irq !== 1'b0) begin
      $display("FAIL tmo_w1c: got %b want 0", irq);
    end else passed++;
  endtask

  task automatic test_busy();
    logic [31:0] d;
    int base;
    base = fire_cnt;
    axi_write(6'h00, 32'h0000_0101, 4'hF);
    axi_write(6'h10, 32'h0, 4'hF);
    axi_write(6'h00, 32'h0000_0301, 4'hF);
    axi_read(6'h04, d);
    checks++;
    if (d !== 32'h1) begin
      $display("FAIL busy_status: got %h want 1", d);
    end else passed++;
    axi_read(6'h10, d);
    checks++;
    if (d !== 32'hDEADBEEF || chal !== 64'h12345678DEADBEEF) begin
      $display("FAIL busy_chal: got %h/%h want deadbeef", d, chal);
    end else passed++;
    pvalid = 1'b1;
    presp = 1'b1;
    @(posedge clk); #1;
    pvalid = 1'b0;
    presp = 1'b0;
    wait_done(d);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (fire_cnt - base !== 1) begin
      $display("FAIL busy_fires: got %0d want 1", fire_cnt - base);
    end else passed++;
    axi_read(6'h08, d);
    checks++;
    if (d !== 32'h0001_0101) begin
      $display("FAIL busy_result: got %h want 00010101", d);
    end else passed++;
    axi_write(6'h10, 32'h0000_00AA, 4'h1);
    axi_read(6'h10, d);
    checks++;
    if (d !== 32'hDEADBEAA || chal[31:0] !== 32'hDEADBEAA) begin
      $display("FAIL strb: got %h/%h want deadbeaa", d, chal[31:0]);
    end else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int gap;
    int w;
    axi_write(6'h00, 32'h0000_0103, 4'hF);
    w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while (!fire && w < 20);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({fire, irq, awready, wready, bvalid, arready, rvalid}
        !== 7'd0 || chal !== 64'd0 || rdata !== 32'd0) begin
      $display("FAIL mid_rst: got f%b i%b c%h want 0",
               fire, irq, chal);
    end else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(6'h04, d);
    checks++;
    if (d !== 32'h0) begin
      $display("FAIL mid_status: got %h want 0", d);
    end else passed++;
    axi_read(6'h00, d);
    checks++;
    if (d !== 32'h0) begin
      $display("FAIL mid_ctrl: got %h want 0", d);
    end else passed++;
    axi_write(6'h00, 32'h0000_0201, 4'hF);
    run_evals(2, 32'h0000_0003, gap);
    wait_done(d);
    checks++;
    if (d !== 32'h2) begin
      $display("FAIL mid_done: got %h want 2", d);
    end else passed++;
    axi_read(6'h08, d);
    checks++;
    if (d !== 32'h0002_0201) begin
      $display("FAIL mid_result: got %h want 00020201", d);
    end else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst_n = 1'b0;
    awaddr = '0;
    awprot = '0;
    awvalid = 1'b0;
    wdata = '0;
    wstrb = '0;
    wvalid = 1'b0;
    bready = 1'b1;
    araddr = '0;
    arprot = '0;
    arvalid = 1'b0;
    rready = 1'b1;
    pvalid = 1'b0;
    presp = 1'b0;
    #1;
    test_reset();
    test_chal();
    test_majority5();
    test_majority4();
    test_timeout();
    test_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/puf_axil_ctrl.md
# puf_axil_ctrl

AXI4-Lite slave controller for the arbiter PUF IP. It holds a parametrised-width challenge register bank and launches the PUF core through a fire/valid handshake. The PUF is evaluated a software-selected number of times and the response is the majority vote of those evaluations. Status, sticky DONE/TIMEOUT flags and a level interrupt let software poll or wait on the result.

## Interface
- C_S_AXI_DATA_WIDTH, 32, AXI data width (fixed 32)
- C_S_AXI_ADDR_WIDTH, 6, byte address width (16 word registers)
- CHAL_WIDTH, 64, challenge bits; multiple of 32, range 32..384
- TIMEOUT_CYCLES, 1024, max cycles waiting for puf_valid per evaluation
- SETTLE_CYCLES, 4, idle cycles between consecutive evaluations (min 1)

- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- S_AXI_AW*/W*/B*/AR*/R*  in/out  standard AXI4-Lite slave channels (AWPROT/ARPROT ignored)
- puf_challenge  out  CHAL_WIDTH  challenge to PUF core, driven from CHAL registers
- puf_fire  out  1  one-cycle launch pulse
- puf_valid  in  1  PUF response valid, one-cycle pulse
- puf_response  in  1  arbiter output bit, sampled when puf_valid=1
- irq  out  1  level interrupt

## Operation
- Register map, byte offsets:
  - 0x00 CTRL, RW. bit0 START: write-1 launches, self-clearing, reads 0. bit1 IRQ_EN. [15:8] NEVAL; 0 is treated as 1.
  - 0x04 STATUS. bit0 BUSY (RO). bit1 DONE, sticky, write-1-to-clear. bit2 TIMEOUT, sticky, W1C.
  - 0x08 RESULT, RO. bit0 majority bit. [15:8] ones count. [23:16] evaluations completed.
  - 0x10 + 4k CHAL word k, RW, for k < CHAL_WIDTH/32. Word 0 holds challenge bits [31:0].
  - All other offsets read 0, writes dropped. BRESP/RRESP always OKAY.
- WSTRB is honoured byte-wise on CTRL and CHAL. STATUS W1C uses byte 0 only.
- While BUSY:
  - CHAL writes are dropped.
  - START is ignored.
  - IRQ_EN writes take effect.
  - NEVAL writes are dropped.
- FSM states IDLE, LAUNCH, WAIT, SETTLE, FINISH:
  - IDLE→LAUNCH on an accepted START write. This clears RESULT, clears DONE and TIMEOUT, and sets BUSY.
  - LAUNCH: puf_fire=1 for exactly one cycle, then →WAIT. The timeout counter loads 0.
  - WAIT, puf_valid=1: ones += puf_response; evals += 1. If evals == NEVAL →FINISH, else →SETTLE.
  - WAIT, counter reaches TIMEOUT_CYCLES-1 without puf_valid: TIMEOUT=1, BUSY=0, majority bit=0, counts keep their partial values, →IDLE.
  - SETTLE: hold SETTLE_CYCLES cycles, then →LAUNCH.
  - FINISH: majority = (2·ones > NEVAL). A tie gives 0. DONE=1, BUSY=0, →IDLE.
- puf_valid outside WAIT is ignored.
- irq = IRQ_EN & (DONE | TIMEOUT). It is combinational from registers.
- puf_challenge is the direct concatenation of the CHAL registers. It is stable for the whole BUSY period.

## Timing
- Reset: every output and register is 0. This covers AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA, puf_fire, puf_challenge, irq and all CSRs. The FSM enters IDLE.
- ARESETN asserted mid-operation aborts immediately. No flags survive.
- Write channel:
  - AWREADY and WREADY pulse together for one cycle when AWVALID & WVALID & !BVALID.
  - BVALID rises the next cycle and holds until BREADY.
  - One write is outstanding at a time.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID & !RVALID.
  - RVALID and RDATA appear the next cycle and hold until RREADY.
  - A read and a write may complete in the same cycle.
- Launch latency: a START handshake in cycle T gives BUSY=1 in T+1 and puf_fire=1 in T+2.
- FINISH sets DONE one cycle after the final puf_valid. irq follows in the same cycle.
- W1C of DONE and a FINISH-set of DONE in the same cycle: the set wins.
- Counts are 8-bit, and NEVAL ≤ 255 guarantees no wrap.

## Test plan
- Reset, then read all 16 offsets → all 0. Write CHAL0=0xDEADBEEF, CHAL1=0x12345678 → puf_challenge=0x12345678DEADBEEF and readback matches.
- NEVAL=5, START. Respond 1,1,0,1,0 → five puf_fire pulses separated by ≥SETTLE_CYCLES+2. RESULT=0x00050301, STATUS DONE=1, BUSY=0.
- NEVAL=4 with responses 1,1,0,0 → majority 0 (tie), RESULT=0x00040200. IRQ_EN=1 → irq=1. Writing STATUS=0x2 → irq=0.
- START, never drive puf_valid → TIMEOUT=1 exactly TIMEOUT_CYCLES cycles after puf_fire, BUSY=0, RESULT=0.
- While BUSY, write CHAL0=0 and START=1 → CHAL0 unchanged, no second sequence. Write with WSTRB=0x1 to CHAL0 when idle → only byte 0 changes.
- Deassert ARESETN while in WAIT → all outputs 0 next edge. After release, a new START runs normally.
